// File: rtl/scan_bist_sequencer.sv
// -----------------------------------------------------------------------------
// scan_bist_sequencer
//
// Session sequencer for a scan-BIST setup: the scan-wrapped CUT, its input and
// state LFSRs, and a MISR. For each of SEQS sequences it reseeds the pattern
// sources (new_seq_o), then runs PATTERNS shift/capture windows. It flushes the
// chain into the MISR and compares the signature with the golden value. All
// comparisons fold into one sticky verdict, which is reported in DONE.
//
// Optional feature: define SCAN_BIST_SEQUENCER_ABORT_EN to add bist_abort_i and
// aborted_o. Abort forces an early DONE with a fail verdict.
//
// Ports:
//   clock_i        : clock, rising edge
//   reset_i        : asynchronous active-high reset
//   bist_start_i   : session request, rising edge detected internally
//   misr_sig_i     : current MISR contents
//   sig_ref_i      : golden signature for the sequence selected by seq_idx_o
//   bist_abort_i   : (ABORT_EN only) abandon the running session
//   scan_en_o      : 1 = shift, 0 = capture/functional
//   new_seq_o      : one-cycle reseed pulse at the start of each sequence
//   bist_running_o : selects LFSR stimulus and enables the LFSRs/MISR
//   seq_idx_o      : index of the active sequence
//   bist_end_o     : session complete, held until the next start edge
//   pass_nfail_o   : 1 only if every sequence matched, valid while bist_end_o=1
//   aborted_o      : (ABORT_EN only) the session ended through an abort
//   state_o        : current FSM state, for observation
// -----------------------------------------------------------------------------
module scan_bist_sequencer #(
    parameter int CHAIN_LEN = 4,
    parameter int PATTERNS  = 8,
    parameter int SEQS      = 2,
    parameter int SIG_W     = 9,
    parameter int IDX_W     = 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             bist_start_i,
`ifdef SCAN_BIST_SEQUENCER_ABORT_EN
    input  logic             bist_abort_i,
    output logic             aborted_o,
`endif
    input  logic [SIG_W-1:0] misr_sig_i,
    input  logic [SIG_W-1:0] sig_ref_i,
    output logic             scan_en_o,
    output logic             new_seq_o,
    output logic             bist_running_o,
    output logic [IDX_W-1:0] seq_idx_o,
    output logic             bist_end_o,
    output logic             pass_nfail_o,
    output logic [2:0]       state_o
);

    localparam int SH_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int PAT_W = (PATTERNS > 1) ? $clog2(PATTERNS) : 1;

    localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(CHAIN_LEN - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(PATTERNS - 1);
    localparam logic [IDX_W-1:0] SEQ_LAST = IDX_W'(SEQS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        FLUSH   = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic [PAT_W-1:0]  pat_cnt_q, pat_cnt_d;
    logic [IDX_W-1:0]  seq_idx_q, seq_idx_d;
    logic              fail_q, fail_d;
    logic              scan_en_q, scan_en_d;
    logic              new_seq_q, new_seq_d;
    logic              running_q, running_d;
    logic              bist_end_q, bist_end_d;
    logic              pass_q, pass_d;
    logic              start_edge;
`ifdef SCAN_BIST_SEQUENCER_ABORT_EN
    logic              aborted_q, aborted_d;
`endif

    assign start_edge = bist_start_i & ~start_q;

    // Outputs are registered: every *_d below is the value for the state being
    // entered, so output changes line up exactly with state changes.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        pat_cnt_d  = pat_cnt_q;
        seq_idx_d  = seq_idx_q;
        fail_d     = fail_q;
        scan_en_d  = 1'b0;
        new_seq_d  = 1'b0;
        running_d  = 1'b0;
        bist_end_d = bist_end_q;
        pass_d     = pass_q;
`ifdef SCAN_BIST_SEQUENCER_ABORT_EN
        aborted_d  = aborted_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d    = INIT;
                    seq_idx_d  = '0;
                    fail_d     = 1'b0;
                    new_seq_d  = 1'b1;
                    running_d  = 1'b1;
                    bist_end_d = 1'b0;
                    pass_d     = 1'b0;
`ifdef SCAN_BIST_SEQUENCER_ABORT_EN
                    aborted_d  = 1'b0;
`endif
                end
            end
            INIT: begin
                state_d   = SHIFT;
                sh_cnt_d  = '0;
                pat_cnt_d = '0;
                scan_en_d = 1'b1;
                running_d = 1'b1;
            end
            SHIFT, FLUSH: begin
                running_d = 1'b1;
                if (sh_cnt_q == SH_LAST) begin
                    sh_cnt_d = '0;
                    state_d  = (state_q == SHIFT) ? CAPTURE : CHECK;
                end else begin
                    sh_cnt_d  = sh_cnt_q + 1'b1;
                    scan_en_d = 1'b1;
                end
            end
            CAPTURE: begin
                running_d = 1'b1;
                scan_en_d = 1'b1;
                if (pat_cnt_q == PAT_LAST) begin
                    pat_cnt_d = '0;
                    state_d   = FLUSH;
                end else begin
                    pat_cnt_d = pat_cnt_q + 1'b1;
                    state_d   = SHIFT;
                end
            end
            CHECK: begin
                fail_d = fail_q | (misr_sig_i != sig_ref_i);
                if (seq_idx_q == SEQ_LAST) begin
                    state_d    = DONE;
                    bist_end_d = 1'b1;
                    pass_d     = ~fail_d;
                end else begin
                    state_d   = INIT;
                    seq_idx_d = seq_idx_q + 1'b1;
                    new_seq_d = 1'b1;
                    running_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef SCAN_BIST_SEQUENCER_ABORT_EN
        // Abort overrides every active-session transition, always with a fail.
        if (bist_abort_i && (state_q != IDLE) && (state_q != DONE)) begin
            state_d    = DONE;
            sh_cnt_d   = '0;
            pat_cnt_d  = '0;
            fail_d     = 1'b1;
            scan_en_d  = 1'b0;
            new_seq_d  = 1'b0;
            running_d  = 1'b0;
            bist_end_d = 1'b1;
            pass_d     = 1'b0;
            aborted_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            sh_cnt_q   <= '0;
            pat_cnt_q  <= '0;
            seq_idx_q  <= '0;
            fail_q     <= 1'b0;
            scan_en_q  <= 1'b0;
            new_seq_q  <= 1'b0;
            running_q  <= 1'b0;
            bist_end_q <= 1'b0;
            pass_q     <= 1'b0;
`ifdef SCAN_BIST_SEQUENCER_ABORT_EN
            aborted_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= bist_start_i;
            sh_cnt_q   <= sh_cnt_d;
            pat_cnt_q  <= pat_cnt_d;
            seq_idx_q  <= seq_idx_d;
            fail_q     <= fail_d;
            scan_en_q  <= scan_en_d;
            new_seq_q  <= new_seq_d;
            running_q  <= running_d;
            bist_end_q <= bist_end_d;
            pass_q     <= pass_d;
`ifdef SCAN_BIST_SEQUENCER_ABORT_EN
            aborted_q  <= aborted_d;
`endif
        end
    end

    assign scan_en_o      = scan_en_q;
    assign new_seq_o      = new_seq_q;
    assign bist_running_o = running_q;
    assign seq_idx_o      = seq_idx_q;
    assign bist_end_o     = bist_end_q;
    assign pass_nfail_o   = pass_q;
    assign state_o        = state_q;
`ifdef SCAN_BIST_SEQUENCER_ABORT_EN
    assign aborted_o      = aborted_q;
`endif

endmodule

// File: doc/scan_bist_sequencer.md
Name: scan_bist_sequencer

Overview:
Multi-sequence scan-BIST session sequencer for the scan-wrapped CUT, its input and state LFSRs, and the MISR.
- Drives scan_en through per-pattern shift/capture windows.
- Pulses new_seq to reseed the LFSRs and MISR at the start of each sequence.
- Unloads the scan chain, then compares the MISR signature against a per-sequence golden value.
- Aggregates the comparisons into one sticky pass/fail verdict with a session-end flag.

Parameters:
- CHAIN_LEN, 4: scan chain length; shift cycles per pattern and per flush.
- PATTERNS, 8: capture patterns per sequence.
- SEQS, 2: sequences per BIST session.
- SIG_W, 9: MISR signature width.
- IDX_W, 1: width of seq_idx; must satisfy 2**IDX_W >= SEQS.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- bist_start, input, 1: session request; a rising edge is detected internally.
- misr_sig, input, SIG_W: current MISR contents.
- sig_ref, input, SIG_W: golden signature for the sequence selected by seq_idx; muxed externally.
- scan_en, output, 1: 1 = shift, 0 = capture/functional.
- new_seq, output, 1: one-cycle pulse; OR'ed into the LFSR/MISR/CUT internal reset.
- bist_running, output, 1: selects LFSR vectors into the CUT and enables the LFSRs/MISR.
- seq_idx, output, IDX_W: index of the active sequence.
- bist_end, output, 1: session complete; held high.
- pass_nfail, output, 1: 1 only when every sequence matched; valid while bist_end=1.

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs 0, all counters 0, start_q=0, fail flag cleared.
- Start detection: start_q registers bist_start. start_edge = bist_start & ~start_q. Accepted only in IDLE or DONE; ignored in all other states.
- IDLE:
  - Outputs all 0.
  - start_edge -> INIT with seq_idx=0 and fail=0.
- INIT (1 cycle):
  - new_seq=1, bist_running=1, scan_en=0.
  - Clears pat_cnt and sh_cnt; next state SHIFT.
- SHIFT:
  - scan_en=1, bist_running=1.
  - sh_cnt counts 0..CHAIN_LEN-1; at CHAIN_LEN-1 -> CAPTURE and sh_cnt resets to 0.
- CAPTURE (1 cycle):
  - scan_en=0, bist_running=1.
  - pat_cnt increments.
  - If pat_cnt was PATTERNS-1 -> FLUSH, else -> SHIFT.
- FLUSH:
  - scan_en=1 for exactly CHAIN_LEN cycles, unloading the last captured state into the MISR.
  - Next state CHECK.
- CHECK (1 cycle):
  - scan_en=0, bist_running=1.
  - If misr_sig != sig_ref, set the fail flag (sticky).
  - If seq_idx == SEQS-1 -> DONE; else seq_idx+1 -> INIT.
- DONE:
  - bist_running=0, scan_en=0, bist_end=1.
  - pass_nfail = ~fail, registered on the entry edge.
  - Both outputs hold until start_edge. A start_edge clears bist_end and pass_nfail in the same edge that enters INIT.
- Cycle count per sequence = 1 + PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1. With defaults this is 46; a full session is 92 cycles from the INIT entry edge to the DONE entry edge.
- Counter widths: each counter is sized with $clog2 to hold its maximum value. Counters never wrap in normal operation; each is reset on its terminal transition.
- Reset mid-session: immediate return to IDLE, all outputs 0. A partial verdict is never reported.
- bist_start held high: no restart. A new session requires a fresh 0->1 transition.
- seq_idx holds at SEQS-1 in DONE; it returns to 0 on the next INIT from DONE.

Optional Feature:
- Macro: SCAN_BIST_SEQUENCER_ABORT_EN.
- With the macro defined:
  - Extra input bist_abort (1) and output aborted (1).
  - bist_abort=1 in any state from INIT through CHECK -> DONE next edge, with bist_end=1, pass_nfail=0, aborted=1.
  - aborted clears on reset or start_edge.
- Without the macro: neither port exists and no abort path is present.

Test Plan:
1. Defaults, misr_sig==sig_ref in both CHECK cycles:
   - new_seq pulses exactly twice, 46 cycles apart.
   - scan_en shows 8 windows of 4 high cycles plus a 4-cycle flush per sequence.
   - bist_end rises 92 cycles after INIT entry; pass_nfail=1.
2. Mismatch in sequence 0 only (misr_sig=9'h08c, sig_ref=9'h08d), match in sequence 1 -> bist_end=1, pass_nfail=0 (sticky fail).
3. Assert reset at cycle 30 of a session:
   - Outputs go to 0 asynchronously before the next clock edge; state is IDLE.
   - A later bist_start 0->1 runs a clean 92-cycle session.
4. Hold bist_start high for 200 cycles:
   - Exactly one session runs; DONE holds bist_end=1.
   - Drop and re-raise bist_start -> bist_end clears and new_seq pulses the following cycle.
5. A bist_start 0->1 edge during SHIFT of sequence 1 is ignored; session timing is unchanged (still 92 cycles).
6. With SCAN_BIST_SEQUENCER_ABORT_EN defined, pulse bist_abort at cycle 20 -> next edge: bist_end=1, pass_nfail=0, aborted=1, scan_en=0, bist_running=0.
